// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with status flags, pass-through tag and valid/ready handshakes.
// Stage 0 captures the combinational ALU result. Stages 1..DEPTH-1 are plain registers.
// Backpressure collapses bubbles, so a stage only stalls when it and every stage after it hold data.
// Optional feature: define ALU_PIPE_SAT_EN to enable signed saturating ADDS/SUBS (opcodes 10/11).
// Without the macro, opcodes 10 and 11 are treated as illegal.

module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_func,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpSll  = 4'd5,
        OpSrl  = 4'd6,
        OpSra  = 4'd7,
        OpSlt  = 4'd8,
        OpSltu = 4'd9,
        OpAdds = 4'd10,
        OpSubs = 4'd11
    } op_e;

    // One pipeline stage: result, flags and the tag that travels with it.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             ovf;
        logic             err;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // ------------------------------------------------------------------
    // Arithmetic building blocks shared by plain and saturating opcodes
    // ------------------------------------------------------------------
    op_e              op;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [ShW-1:0]   shamt;

    assign op          = op_e'(in_func);
    assign add_full    = {1'b0, in_a} + {1'b0, in_b};
    assign sum         = add_full[WIDTH-1:0];
    assign diff        = in_a - in_b;
    assign borrow      = in_a < in_b;
    assign lt_signed   = $signed(in_a) < $signed(in_b);
    assign lt_unsigned = borrow;
    // Operands of equal sign whose sum has the other sign.
    assign add_ovf     = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    // Operands of differing sign whose difference takes the sign of b.
    assign sub_ovf     = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
    // Upper bits of b are deliberately ignored for shifts.
    assign shamt       = in_b[ShW-1:0];

`ifdef ALU_PIPE_SAT_EN
    logic [WIDTH-1:0] sat_max;
    logic [WIDTH-1:0] sat_min;

    assign sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    assign sat_min = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // ------------------------------------------------------------------
    // Combinational ALU feeding stage 0
    // ------------------------------------------------------------------
    stage_t alu_st;

    // Decode opcode into result and flags; illegal opcodes yield result 0 with err set.
    always_comb begin
        alu_st        = '0;
        alu_st.tag    = in_tag;
        unique case (op)
            OpAdd: begin
                alu_st.result = sum;
                alu_st.carry  = add_full[WIDTH];
                alu_st.ovf    = add_ovf;
            end
            OpSub: begin
                alu_st.result = diff;
                alu_st.carry  = borrow;
                alu_st.ovf    = sub_ovf;
            end
            OpAnd:  alu_st.result = in_a & in_b;
            OpOr:   alu_st.result = in_a | in_b;
            OpXor:  alu_st.result = in_a ^ in_b;
            OpSll:  alu_st.result = in_a << shamt;
            OpSrl:  alu_st.result = in_a >> shamt;
            OpSra:  alu_st.result = WIDTH'($signed(in_a) >>> shamt);
            OpSlt:  alu_st.result = {{(WIDTH-1){1'b0}}, lt_signed};
            OpSltu: alu_st.result = {{(WIDTH-1){1'b0}}, lt_unsigned};
`ifdef ALU_PIPE_SAT_EN
            // On overflow the true result has the sign of a, so clamp towards it.
            OpAdds: begin
                alu_st.ovf    = add_ovf;
                alu_st.result = add_ovf ? (in_a[WIDTH-1] ? sat_min : sat_max) : sum;
            end
            OpSubs: begin
                alu_st.ovf    = sub_ovf;
                alu_st.result = sub_ovf ? (in_a[WIDTH-1] ? sat_min : sat_max) : diff;
            end
`endif
            default: alu_st.err = 1'b1;
        endcase
        alu_st.zero = (alu_st.result == '0);
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] v_q;
    stage_t           st_q [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             rdy_acc;

    // Ready chain: stage k can load unless it and all downstream stages are full and stalled.
    // Unrolled as an accumulator so no bit of rdy depends on another bit of rdy.
    always_comb begin
        rdy        = '0;
        rdy_acc    = out_ready;
        rdy[DEPTH] = out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            rdy_acc = rdy_acc | ~v_q[k];
            rdy[k]  = rdy_acc;
        end
    end

    // Stage registers: load from predecessor when ready, hold otherwise; reset clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                st_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_q[0]  <= in_valid;
                st_q[0] <= alu_st;
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (rdy[k]) begin
                    v_q[k]  <= v_q[k-1];
                    st_q[k] <= st_q[k-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = rdy[0];
    assign out_valid  = v_q[DEPTH-1];
    assign out_result = st_q[DEPTH-1].result;
    assign out_zero   = st_q[DEPTH-1].zero;
    assign out_carry  = st_q[DEPTH-1].carry;
    assign out_ovf    = st_q[DEPTH-1].ovf;
    assign out_err    = st_q[DEPTH-1].err;
    assign out_tag    = st_q[DEPTH-1].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven bench for alu_pipe (WIDTH=32, DEPTH=2, TAG_W=4).
// Expected values for ADDS/SUBS follow ALU_PIPE_SAT_EN, the same macro the RTL uses.

module tb_alu_pipe;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_func;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_carry;
    logic          out_ovf;
    logic          out_err;
    logic [TW-1:0] out_tag;

    alu_pipe #(
        .WIDTH (W),
        .DEPTH (D),
        .TAG_W (TW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func    (in_func),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_err    (out_err),
        .out_tag    (out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         name;
        logic [3:0]    func;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          z;
        logic          c;
        logic          o;
        logic          e;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string name, input logic [3:0] func, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [TW-1:0] tag,
                                input logic [W-1:0] res, input logic z, input logic c,
                                input logic o, input logic e);
        vec_t v;
        v.name = name; v.func = func; v.a = a; v.b = b; v.tag = tag;
        v.res = res; v.z = z; v.c = c; v.o = o; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_pack();
        return 64'({out_result, out_zero, out_carry, out_ovf, out_err, out_tag});
    endfunction

    function automatic logic [63:0] exp_pack(input vec_t v);
        return 64'({v.res, v.z, v.c, v.o, v.e, v.tag});
    endfunction

    // Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one operation, then check latency and the result D edges after acceptance.
    task automatic apply(input vec_t v);
        in_valid = 1'b1;
        in_func  = v.func;
        in_a     = v.a;
        in_b     = v.b;
        in_tag   = v.tag;
        check({v.name, " in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({v.name, " early out_valid"}, 64'(out_valid), 64'd0);
        tick();
        check({v.name, " out_valid"}, 64'(out_valid), 64'd1);
        check({v.name, " result/flags/tag"}, out_pack(), exp_pack(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv;
        int stall_left;
        int blocked;
        bit stall_done;
        bit released;
        bit fire_in;
        bit fire_out;
        logic exp_ready;

        // result, zero, carry, ovf, err
        vecs.push_back(mk("add 2+3",     4'd0,  32'd2,         32'd3,         4'd1,  32'd5,         0, 0, 0, 0));
        vecs.push_back(mk("add 5+3",     4'd0,  32'd5,         32'd3,         4'd2,  32'd8,         0, 0, 0, 0));
        vecs.push_back(mk("sub 5-5",     4'd1,  32'd5,         32'd5,         4'd3,  32'd0,         1, 0, 0, 0));
        vecs.push_back(mk("sub 3-5",     4'd1,  32'd3,         32'd5,         4'd4,  32'hFFFFFFFE,  0, 1, 0, 0));
        vecs.push_back(mk("add carry",   4'd0,  32'hFFFFFFFF,  32'd1,         4'd5,  32'd0,         1, 1, 0, 0));
        vecs.push_back(mk("add ovf",     4'd0,  32'h7FFFFFFF,  32'd1,         4'd6,  32'h80000000,  0, 0, 1, 0));
        vecs.push_back(mk("sub ovf",     4'd1,  32'h80000000,  32'd1,         4'd7,  32'h7FFFFFFF,  0, 0, 1, 0));
`ifdef ALU_PIPE_SAT_EN
        vecs.push_back(mk("adds sat",    4'd10, 32'h7FFFFFFF,  32'd1,         4'd8,  32'h7FFFFFFF,  0, 0, 1, 0));
        vecs.push_back(mk("subs sat",    4'd11, 32'h80000000,  32'd1,         4'd9,  32'h80000000,  0, 0, 1, 0));
        vecs.push_back(mk("adds plain",  4'd10, 32'd4,         32'd5,         4'd10, 32'd9,         0, 0, 0, 0));
`else
        vecs.push_back(mk("adds illegal", 4'd10, 32'h7FFFFFFF, 32'd1,         4'd8,  32'd0,         1, 0, 0, 1));
        vecs.push_back(mk("subs illegal", 4'd11, 32'h80000000, 32'd1,         4'd9,  32'd0,         1, 0, 0, 1));
`endif
        vecs.push_back(mk("and",         4'd2,  32'hF0F0F0F0,  32'hFF00FF00,  4'd11, 32'hF000F000,  0, 0, 0, 0));
        vecs.push_back(mk("or",          4'd3,  32'hF0F0F0F0,  32'hFF00FF00,  4'd12, 32'hFFF0FFF0,  0, 0, 0, 0));
        vecs.push_back(mk("xor",         4'd4,  32'hF0F0F0F0,  32'hFF00FF00,  4'd13, 32'h0FF00FF0,  0, 0, 0, 0));
        vecs.push_back(mk("sll",         4'd5,  32'd1,         32'h21,        4'd14, 32'd2,         0, 0, 0, 0));
        vecs.push_back(mk("srl",         4'd6,  32'h80000000,  32'd4,         4'd15, 32'h08000000,  0, 0, 0, 0));
        vecs.push_back(mk("sra",         4'd7,  32'h80000000,  32'h24,        4'd0,  32'hF8000000,  0, 0, 0, 0));
        vecs.push_back(mk("slt",         4'd8,  32'hFFFFFFFF,  32'd1,         4'd1,  32'd1,         0, 0, 0, 0));
        vecs.push_back(mk("sltu",        4'd9,  32'hFFFFFFFF,  32'd1,         4'd2,  32'd0,         1, 0, 0, 0));
        vecs.push_back(mk("func 13",     4'd13, 32'd7,         32'd9,         4'd3,  32'd0,         1, 0, 0, 1));

        // Reset state.
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_func   = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset outputs", out_pack(), 64'd0);

        foreach (vecs[i]) apply(vecs[i]);
        tick();

        // Backpressure: stream tags 0..5, stall the consumer 4 cycles once tag 0 is valid.
        sent       = 0;
        rcv        = 0;
        stall_left = 0;
        blocked    = 0;
        stall_done = 0;
        released   = 0;
        for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
            if (!stall_done && out_valid) begin
                stall_done = 1;
                stall_left = 4;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 6);
            in_func   = 4'd0;
            in_a      = 32'(sent * 10);
            in_b      = 32'd1;
            in_tag    = 4'(sent);
            #1;
            // Full means D operations inside; then only a draining consumer frees a slot.
            exp_ready = ((sent - rcv) < D) || out_ready;
            check("bp in_ready", 64'(in_ready), 64'(exp_ready));
            if (!in_ready) blocked++;
            if (out_valid) begin
                check("bp tag order", 64'(out_tag), 64'(rcv));
                check("bp result", 64'(out_result), 64'(rcv * 10 + 1));
            end
            if (released) check("bp no gap", 64'(out_valid), 64'd1);
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            tick();
            if (fire_in) sent++;
            if (fire_out) rcv++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) released = 1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp all received", 64'(rcv), 64'd6);
        check("bp blocked cycles", 64'(blocked), 64'd4);
        tick();
        tick();

        // Reset with operations in flight; the op offered during reset is not accepted.
        in_valid = 1'b1;
        in_func  = 4'd0;
        in_a     = 32'd7;
        in_b     = 32'd7;
        in_tag   = 4'd9;
        tick();
        in_tag = 4'd10;
        tick();
        reset  = 1'b1;
        in_tag = 4'd11;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset outputs", out_pack(), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midreset stale", 64'(out_valid), 64'd0);
        end
        apply(mk("post-reset add", 4'd0, 32'd1, 32'd1, 4'd3, 32'd2, 0, 0, 0, 0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the single-cycle combinational `alu`. It adds configurable data width and pipeline depth, a 4-bit opcode space, status flags, a pass-through tag and valid/ready handshakes on both sides. It sits between an operand-issue stage and a result consumer, and is intended to be driven from a ChiselVerify bench. Func code 0 keeps its ADD meaning.

## Interface
- `WIDTH`, default 32, operand/result width; ≥ 8, power of 2.
- `DEPTH`, default 2, pipeline register stages; range 1..4.
- `TAG_W`, default 4, width of the opaque tag carried alongside each operation.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: block can accept.
- `in_func` in 4: opcode.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B.
- `in_tag` in TAG_W: tag, returned unchanged with the result.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `out_result` out WIDTH: result.
- `out_zero` out 1: result == 0.
- `out_carry` out 1: unsigned carry (ADD) or borrow (SUB).
- `out_ovf` out 1: signed overflow.
- `out_err` out 1: illegal opcode.
- `out_tag` out TAG_W: tag of this result.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 SLL; 6 SRL; 7 SRA. Shift amount is `b[log2(WIDTH)-1:0]`; upper bits of b are ignored.
  - 8 SLT (signed) and 9 SLTU (unsigned): result is 1 or 0, zero-extended.
  - 10 ADDS, 11 SUBS: see Configuration.
  - 12–15: illegal.
- Flags:
  - ADD: carry = carry-out of bit WIDTH-1; ovf = operands share a sign and the result sign differs.
  - SUB: carry = borrow (unsigned a < b); ovf = signed overflow of a−b.
  - All other opcodes: carry = ovf = 0.
  - zero is always computed from the final result.
- Illegal opcode: result = 0, zero = 1, carry = 0, ovf = 0, err = 1. The operation still flows through the pipeline and is not dropped.
- Datapath: result and flags are computed combinationally from the accepted inputs and captured into stage 0. Stages 1..DEPTH-1 are pure registers. The last stage drives `out_*`.
- Each stage k has a valid bit v[k].
- Bubble-collapsing backpressure:
  - `ready[DEPTH] = out_ready`.
  - `ready[k] = !v[k] || ready[k+1]`.
  - `in_ready = ready[0]`, a combinational chain with no registered stall.
- A stage loads from its predecessor when `ready[k]` is high. It keeps its contents otherwise.
- Ordering is strictly FIFO. No operation is lost or duplicated.

## Timing
- Reset, at the clock edge with `reset` = 1: all v[k] = 0. Therefore `out_valid` = 0 and `in_ready` = 1 in the next cycle.
- At reset, `out_result`, flags and `out_tag` are 0. Data registers clear on reset.
- Reset asserted mid-stream discards all in-flight operations, and nothing is emitted afterwards. If `in_valid` is high during the reset cycle, that operation is not accepted.
- Acceptance happens at the edge where `in_valid && in_ready`. The result appears with `out_valid` = 1 in the cycle after edge k+DEPTH-1, i.e. DEPTH cycles after the operation was presented, when there is no backpressure.
- Throughput is 1 operation per cycle while `out_ready` = 1.
- With `out_ready` = 0, exactly DEPTH operations are absorbed. `in_ready` falls combinationally once all stages are valid.
- Same-cycle accept and release are allowed when full: if `out_ready` = 1, `in_ready` = 1 in the same cycle.
- While `out_valid && !out_ready`, `out_*` must be held stable.

## Configuration
- `ALU_PIPE_SAT_EN` defined:
  - ADDS and SUBS are signed saturating. On overflow, the result clamps to 0x7F…F (positive) or 0x80…0 (negative), and ovf = 1.
  - carry = 0; err = 0.
- Not defined: opcodes 10 and 11 are illegal (result 0, err = 1). No saturation logic is synthesised.

## Test plan
All scenarios use WIDTH = 32, DEPTH = 2, `out_ready` = 1 unless stated.
- ADD a=2, b=3, tag 1 → `out_result` = 5, zero = carry = ovf = err = 0, tag 1. `out_valid` rises DEPTH cycles after acceptance. Then a=5, b=3 → 8.
- SUB 5−5 → 0 with zero = 1. SUB 3−5 → 0xFFFFFFFE with carry = 1, ovf = 0. ADD 0xFFFFFFFF+1 → 0 with carry = 1, zero = 1.
- ADD 0x7FFFFFFF+1 → 0x80000000 with ovf = 1. Same operands as ADDS: 0x7FFFFFFF with ovf = 1 when `ALU_PIPE_SAT_EN` is defined; result 0 with err = 1 when it is not.
- SRA 0x80000000 by b = 0x24 (amount 4) → 0xF8000000. SLT 0xFFFFFFFF, 1 → 1. SLTU with the same operands → 0. Func 13 → result 0, err = 1.
- Backpressure: stream tags 0..5 back-to-back and hold `out_ready` = 0 for 4 cycles once tag 0 is valid.
  - `in_ready` drops after 2 operations are held.
  - After release, tags 0..5 emerge in order with correct results and no gaps beyond the stall.
- Reset with 2 operations in flight → `out_valid` = 0 in the next cycle, no stale result appears afterwards, and a new ADD 1+1 → 2 completes normally.
